// File: rtl/seq_player_m.sv
// Scripted board-game player: plays queued cell choices, falls back to the lowest
// free cell when the script runs dry, and handshakes each move with the board.
module seq_player_m #(
  parameter int         CELLS = 9,
  parameter int         IDX_W = 4,
  parameter int         DEPTH = 8,
  parameter int         DELAY = 2,
  parameter logic [1:0] MARK  = 2'b01
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                turn,
  input  logic [CELLS-1:0]                    occupied,
  input  logic                                ack,
  input  logic                                load_en,
  input  logic [IDX_W-1:0]                    load_loc,
  input  logic                                new_game,
  output tri   [IDX_W-1:0]                    update_loc,
  output tri   [1:0]                          update_val,
  output tri                                  submit,
  output tri                                  reset,
  output logic                                no_move,
  output logic [$clog2(DEPTH+CELLS+1)-1:0]    round
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = $clog2(DEPTH + CELLS + 1);
  localparam int DW = (DELAY > 1) ? $clog2(DELAY) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_DELAY, ST_PICK, ST_SUBMIT, ST_WAIT_ACK, ST_DONE
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DW-1:0]     dly_cnt;
  logic              turn_d, ng_pend, reset_q, from_script;
  logic [IDX_W-1:0]  loc_q;

  logic [IDX_W-1:0]  entry, fb_loc, pick_loc;
  logic              entry_ok, fb_found, script_avail, ng_req, ng_take, start;
  logic              rd_inc, rnd_inc, pick_latch, pick_script, nm_set, dly_inc;
  logic              load_ok, move_phase;

  assign entry        = mem[rd_ptr[AW-1:0]];
  assign script_avail = (rd_ptr < wr_ptr);
  assign ng_req       = new_game | ng_pend;
  assign ng_take      = (state == ST_IDLE) && !turn && ng_req;
  // A pending new game wins over the turn start; the turn begins one cycle later.
  assign start        = (state == ST_IDLE) && !turn && turn_d && !ng_req;
  assign load_ok      = load_en && (state == ST_IDLE) && (wr_ptr < PW'(DEPTH));

  always_comb begin
    entry_ok = 1'b0;
    for (int i = 0; i < CELLS; i++)
      if (entry == IDX_W'(i) && !occupied[i]) entry_ok = 1'b1;
    fb_found = 1'b0;
    fb_loc   = '0;
    for (int i = CELLS - 1; i >= 0; i--)
      if (!occupied[i]) begin
        fb_found = 1'b1;
        fb_loc   = IDX_W'(i);
      end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    rd_inc      = 1'b0;
    rnd_inc     = 1'b0;
    pick_latch  = 1'b0;
    pick_loc    = '0;
    pick_script = 1'b0;
    nm_set      = 1'b0;
    dly_inc     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_n = (DELAY == 0) ? ST_PICK : ST_DELAY;
      end
      ST_DELAY: begin
        if (turn)                           state_n = ST_IDLE;
        else if (dly_cnt == DW'(DELAY - 1)) state_n = ST_PICK;
        else                                dly_inc = 1'b1;
      end
      ST_PICK: begin
        if (turn) begin
          state_n = ST_IDLE;
        end else if (script_avail) begin
          if (entry_ok) begin
            pick_latch  = 1'b1;
            pick_loc    = entry;
            pick_script = 1'b1;
            state_n     = ST_SUBMIT;
          end else begin
            rd_inc = 1'b1;
          end
        end else if (fb_found) begin
          pick_latch = 1'b1;
          pick_loc   = fb_loc;
          state_n    = ST_SUBMIT;
        end else begin
          nm_set  = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_SUBMIT, ST_WAIT_ACK: begin
        // An abort leaves rd_ptr alone so the same entry is offered next turn.
        if (turn) begin
          state_n = ST_IDLE;
        end else if (ack) begin
          rd_inc  = from_script;
          rnd_inc = 1'b1;
          state_n = ST_DONE;
        end else begin
          state_n = ST_WAIT_ACK;
        end
      end
      ST_DONE: begin
        if (turn) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load_ok) mem[wr_ptr[AW-1:0]] <= load_loc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      round       <= '0;
      no_move     <= 1'b0;
      turn_d      <= 1'b1;
      ng_pend     <= 1'b0;
      reset_q     <= 1'b0;
      loc_q       <= '0;
      from_script <= 1'b0;
      dly_cnt     <= '0;
    end else begin
      turn_d  <= ng_take ? 1'b1 : turn;
      reset_q <= ng_take;
      no_move <= nm_set;
      if (ng_take)       ng_pend <= 1'b0;
      else if (new_game) ng_pend <= 1'b1;
      if (load_ok) wr_ptr <= wr_ptr + 1'b1;
      if (ng_take) begin
        rd_ptr <= '0;
        round  <= '0;
      end else begin
        if (rd_inc) rd_ptr <= rd_ptr + 1'b1;
        if (rnd_inc && round != {RW{1'b1}}) round <= round + 1'b1;
      end
      if (pick_latch) begin
        loc_q       <= pick_loc;
        from_script <= pick_script;
      end
      if (state != ST_DELAY) dly_cnt <= '0;
      else if (dly_inc)      dly_cnt <= dly_cnt + 1'b1;
    end
  end

  assign move_phase = (state == ST_SUBMIT) || (state == ST_WAIT_ACK);

  assign update_loc = turn ? {IDX_W{1'bz}} : (move_phase ? loc_q : '0);
  assign update_val = turn ? 2'bzz : (move_phase ? MARK : 2'b00);
  assign submit     = turn ? 1'bz : (state == ST_SUBMIT);
  assign reset      = turn ? 1'bz : reset_q;

endmodule

// File: tb/tb_seq_player_m.sv
// Scoreboard bench for seq_player_m: stimulus queues expected moves, a negedge
// monitor pops and compares every submitted move.
module tb_seq_player_m;

  logic       clk = 1'b0;
  logic       rst_n, turn, ack, load_en, new_game;
  logic [8:0] occupied;
  logic [3:0] load_loc;
  tri   [3:0] update_loc;
  tri   [1:0] update_val;
  tri         submit, reset;
  logic       no_move;
  logic [4:0] round;

  seq_player_m dut (
    .clk(clk), .rst_n(rst_n), .turn(turn), .occupied(occupied), .ack(ack),
    .load_en(load_en), .load_loc(load_loc), .new_game(new_game),
    .update_loc(update_loc), .update_val(update_val), .submit(submit),
    .reset(reset), .no_move(no_move), .round(round)
  );

  always #5 clk = ~clk;

  typedef struct { int loc; int cyc; } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_submit = 0;
  int nm_cnt = 0;
  int rst_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  // Monitor: every submit seen on the driven bus is matched against the queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && turn === 1'b0) begin
      if (submit === 1'b1) begin
        n_submit++;
        if (exp_q.size() == 0) begin
          chk("unexpected_submit", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("submit_loc", int'(update_loc), e.loc);
          chk("submit_val", int'(update_val), 1);
          chk("submit_cycle", cyc, e.cyc);
        end
      end
      if (reset === 1'b1) rst_cnt++;
    end
    if (rst_n === 1'b1 && no_move === 1'b1) nm_cnt++;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; turn = 1'b1; ack = 1'b0; load_en = 1'b0;
    new_game = 1'b0; occupied = '0; load_loc = '0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic load(input int v);
    @(posedge clk); #1;
    load_en = 1'b1; load_loc = 4'(v);
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic start_turn(input int loc, input int lat);
    exp_t e;
    @(posedge clk); #1;
    turn = 1'b0;
    e.loc = loc; e.cyc = cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_submit();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (turn === 1'b0 && submit === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("submit_timeout", 0, 1);
  endtask

  task automatic do_ack(input int hold);
    repeat (hold) @(negedge clk);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic end_turn();
    @(posedge clk); #1;
    turn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, n0, r0;
    rst_n = 1'b0; turn = 1'b1; ack = 1'b0; load_en = 1'b0;
    new_game = 1'b0; occupied = '0; load_loc = '0;
    repeat (2) @(posedge clk);
    // Driven values while held in reset.
    #1 turn = 1'b0;
    #1;
    chk("rst_submit", int'(submit), 0);
    chk("rst_reset", int'(reset), 0);
    chk("rst_loc", int'(update_loc), 0);
    chk("rst_val", int'(update_val), 0);
    chk("rst_round", int'(round), 0);
    chk("rst_no_move", int'(no_move), 0);
    turn = 1'b1;

    // Basic script play and latency.
    do_reset();
    load(0); load(2); load(5); load(4);
    start_turn(0, 4);
    wait_submit();
    do_ack(0);
    @(negedge clk);
    chk("round_after_first", int'(round), 1);
    end_turn();

    // Occupied script entry is skipped.
    do_reset();
    load(0); load(2);
    occupied = 9'b000000001;
    start_turn(2, 5);
    wait_submit();
    do_ack(0);
    @(negedge clk);
    chk("round_after_skip", int'(round), 1);
    end_turn();

    // Empty script falls back to lowest free cell.
    do_reset();
    occupied = 9'b000000111;
    start_turn(3, 4);
    wait_submit();
    do_ack(0);
    @(negedge clk);
    chk("round_after_fallback", int'(round), 1);
    end_turn();

    // Full board: no_move pulse, no submit.
    do_reset();
    occupied = 9'h1FF;
    s0 = n_submit; n0 = nm_cnt;
    @(posedge clk); #1 turn = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("no_move_pulses", nm_cnt - n0, 1);
    chk("no_move_submits", n_submit - s0, 0);
    chk("no_move_round", int'(round), 0);
    end_turn();

    // Abort during WAIT_ACK, entry retried next turn.
    do_reset();
    load(3); load(6);
    occupied = '0;
    start_turn(3, 4);
    wait_submit();
    repeat (2) @(negedge clk);
    end_turn();
    @(negedge clk);
    chk("round_after_abort", int'(round), 0);
    start_turn(3, 4);
    wait_submit();
    do_ack(0);
    @(negedge clk);
    chk("round_after_retry", int'(round), 1);
    end_turn();
    start_turn(6, 4);
    wait_submit();
    do_ack(0);
    @(negedge clk);
    chk("round_after_second", int'(round), 2);
    end_turn();

    // new_game while opponent's turn, honoured at next turn start.
    @(posedge clk); #1 new_game = 1'b1;
    @(posedge clk); #1 new_game = 1'b0;
    repeat (2) @(posedge clk);
    r0 = rst_cnt;
    start_turn(3, 5);
    wait_submit();
    chk("new_game_reset_pulses", rst_cnt - r0, 1);
    chk("new_game_round", int'(round), 0);
    do_ack(2);
    @(negedge clk);
    chk("round_after_wait_ack", int'(round), 1);
    end_turn();

    // Script full: ninth load ignored; all entries invalid, fallback picks cell 1.
    do_reset();
    for (int i = 0; i < 8; i++) load(15);
    load(4);
    occupied = 9'b000000001;
    start_turn(1, 12);
    wait_submit();
    do_ack(0);
    end_turn();

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
